fw_image_responder: RTL and testbench
=====================================

Name: fw_image_responder

Overview:
- Responder side of the firmware fetch interface that the hardware bootloader drives.
- Accepts word-address requests (firmware_addr_req / firmware_req_valid) and reads the boot image from a synchronous on-chip ROM/flash-mirror port.
- Returns firmware_addr / firmware_data / firmware_data_valid to the bootloader.
- Buffers requests, rejects illegal addresses, counts dropped requests.

Parameters:
ADDR_W, 32, byte-address width of requests and memory port
DATA_W, 32, data word width (4-byte words)
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
MEM_LATENCY, 2, cycles from mem_rd_en high to mem_rdata valid (>=1)
IMAGE_BYTES, 65536, image size in bytes; legal addresses are 0..IMAGE_BYTES-4

Ports:
clk  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
firmware_addr_req  in  ADDR_W  requested byte address
firmware_req_valid  in  1  single-cycle request strobe
flush  in  1  synchronous abort: clears FIFO and in-flight read
req_ready  out  1  FIFO not full (registered occupancy)
mem_rd_en  out  1  one-cycle memory read strobe
mem_addr  out  ADDR_W  memory byte address, held from strobe to capture
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after strobe
firmware_addr  out  ADDR_W  address of current response or error
firmware_data  out  DATA_W  response data
firmware_data_valid  out  1  one-cycle response strobe
req_error  out  1  one-cycle strobe for misaligned or out-of-range request
drop_cnt  out  16  saturating count of requests lost while FIFO full
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
Reset:
- All outputs, FIFO pointers and occupancy, and drop_cnt are 0; state is IDLE.
- Asynchronous assertion clears everything immediately. Any in-flight memory read is discarded.

Request intake:
- A request is accepted when firmware_req_valid=1 and req_ready=1.
- req_ready derives only from registered occupancy. There is no same-cycle bypass: a full FIFO refuses a request even if it pops in that cycle.
- A strobe while req_ready=0 is lost and increments drop_cnt, saturating at 0xFFFF.

FSM (IDLE, READ, WAIT, RESP):
- IDLE: if FIFO non-empty and flush=0, pop the head.
  - Misaligned head (addr[1:0]!=0) or addr > IMAGE_BYTES-4: next cycle req_error=1 with firmware_addr=addr; no mem_rd_en; stay IDLE.
  - Legal head: register mem_addr=addr, go to READ.
- READ: mem_rd_en=1 for exactly one cycle; load latency counter with MEM_LATENCY-1; go to WAIT.
- WAIT: decrement the counter. At 0, mem_rdata is valid that cycle: capture it and go to RESP.
- RESP: firmware_data_valid=1 for one cycle, with firmware_addr=mem_addr and the captured firmware_data; return to IDLE.
- Outputs firmware_addr and firmware_data hold their last values between strobes.

Latency and ordering:
- Request accepted in cycle N into an empty FIFO while IDLE: mem_rd_en in N+2, firmware_data_valid in N+3+MEM_LATENCY (N+5 at default).
- Throughput is one response per MEM_LATENCY+3 cycles. Responses are strictly in request order, with one memory read outstanding.

Flush:
- Takes priority over everything except reset.
- Next cycle: FIFO empty, state IDLE, mem_rd_en=0, no data_valid or req_error for any pending or in-flight request.
- A request strobe in the flush cycle is discarded and not counted as dropped.
- drop_cnt is not cleared.

Simultaneous events:
- Push and pop in the same cycle leave occupancy unchanged.
- Intake and response strobes are independent; intake continues during READ, WAIT and RESP.

Arithmetic:
- Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- The range check uses the full ADDR_W bits with no wrap. 0xFFFF_FFFC is out of range.

Decomposition:
- Package fw_fetch_pkg holds:
  - state enum (IDLE, READ, WAIT, RESP)
  - WORD_BYTES=4
  - the range-check helper function
  - DROP_CNT_W=16
- One sub-module, fw_req_fifo: synchronous FIFO of ADDR_W entries with push, pop, flush, full, empty and count.

Test Plan:
1. ROM word 0 = 0x0000_0100; req addr 0x0 in cycle N -> mem_rd_en in N+2 with mem_addr 0x0; firmware_data_valid in N+5 with addr 0x0, data 0x0000_0100; busy low in N+6.
2. Strobes on consecutive cycles for 0x4, 0x8, 0xC, 0x10, 0x14 with ROM word k = k -> req_ready low after 4 accepts; 0x14 lost, drop_cnt=1; four responses in order, data 1..4, spaced 5 cycles.
3. Req 0x6 in cycle N -> req_error=1 in N+2 with firmware_addr=0x6; no mem_rd_en; no firmware_data_valid; drop_cnt unchanged.
4. Req 0x10000 and req 0xFFFC (IMAGE_BYTES=65536) -> 0x10000 gives req_error; 0xFFFC returns the ROM's last word with data_valid.
5. Three queued requests, flush asserted while the first is in WAIT -> no responses; next cycle busy=0 and req_ready=1; a subsequent req 0x8 is served normally.
6. reset_n low mid-WAIT with drop_cnt=3 -> all outputs 0 immediately, drop_cnt=0; stale mem_rdata after release is ignored; new req 0x0 responds in 5 cycles.

Source files
------------

// File: rtl/fw_fetch_pkg.sv
// Shared definitions for the firmware fetch responder.
//   fetch_state_e  : responder FSM states
//   WORD_BYTES     : bytes per image word
//   DROP_CNT_W     : width of the saturating drop counter
//   addr_in_image(): true when a byte address is word aligned and lies
//                    inside an image of image_bytes bytes (no wrap).
package fw_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

  localparam int WORD_BYTES = 4;
  localparam int DROP_CNT_W = 16;

  // Operands are widened to 64 bits by the caller so the comparison never
  // wraps, e.g. 0xFFFF_FFFC is plainly larger than any legal address.
  function automatic logic addr_in_image(input logic [63:0] addr,
                                         input logic [63:0] image_bytes);
    return (addr[1:0] == 2'b00) && (addr <= image_bytes - 64'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/fw_req_fifo.sv
// Synchronous request FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (ignored when full)
//   pop/rdata  : rdata is the head entry; pop removes it (ignored when empty)
//   flush      : empties the FIFO next cycle, overriding push and pop
//   full/empty/count : derived from registered occupancy only
module fw_req_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fw_image_responder.sv
// Firmware fetch responder: queues bootloader word requests, reads the boot
// image from a synchronous memory port, and returns address/data strobes.
//   clk, reset_n          : clock, asynchronous active-low reset
//   firmware_addr_req     : requested byte address
//   firmware_req_valid    : request strobe
//   flush                 : synchronous abort of queued and in-flight work
//   req_ready             : request FIFO not full
//   mem_rd_en / mem_addr  : one-cycle read strobe, address held to capture
//   mem_rdata             : read data, valid MEM_LATENCY cycles after strobe
//   firmware_addr/_data   : response (or error) address and data, held
//   firmware_data_valid   : one-cycle response strobe
//   req_error             : one-cycle strobe for misaligned/out-of-range
//   drop_cnt              : saturating count of requests refused while full
//   busy                  : FSM not idle or FIFO non-empty
//   state_dbg             : current FSM state
//
// Handshake: a request is taken on a cycle where firmware_req_valid=1,
// req_ready=1 and flush=0. req_ready comes from registered occupancy only,
// so a full FIFO refuses even when it pops that cycle; such a refused
// strobe is counted in drop_cnt. A strobe during flush is simply discarded.
module fw_image_responder
  import fw_fetch_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_LATENCY = 2,
  parameter int IMAGE_BYTES = 65536
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     firmware_addr_req,
  input  logic                  firmware_req_valid,
  input  logic                  flush,
  output logic                  req_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     firmware_addr,
  output logic [DATA_W-1:0]     firmware_data,
  output logic                  firmware_data_valid,
  output logic                  req_error,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  fetch_state_e          state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]     fw_addr_q, fw_addr_d;
  logic [DATA_W-1:0]     fw_data_q, fw_data_d;
  logic                  req_error_q, req_error_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]     fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  assign req_ready = ~fifo_full;
  assign fifo_push = firmware_req_valid & req_ready & ~flush;

  fw_req_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (firmware_addr_req),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The head stays queued while it is being served and is retired when its
  // response (or error) is issued, so occupancy also covers the single
  // outstanding memory read.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    fw_addr_d   = fw_addr_q;
    fw_data_d   = fw_data_q;
    req_error_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (addr_in_image(64'(fifo_head), 64'(IMAGE_BYTES))) begin
            mem_addr_d = fifo_head;
            state_d    = ST_READ;
          end else begin
            fifo_pop    = 1'b1;
            req_error_d = 1'b1;
            fw_addr_d   = fifo_head;
          end
        end
      end
      ST_READ: begin
        lat_d   = LAT_W'(MEM_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          fw_data_d = mem_rdata;
          fw_addr_d = mem_addr_q;
          state_d   = ST_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        fifo_pop = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush abandons everything pending; response registers keep old values.
    if (flush) begin
      state_d     = ST_IDLE;
      lat_d       = '0;
      mem_addr_d  = mem_addr_q;
      fw_addr_d   = fw_addr_q;
      fw_data_d   = fw_data_q;
      req_error_d = 1'b0;
      fifo_pop    = 1'b0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (firmware_req_valid && !req_ready && !flush && (drop_q != '1))
      drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      fw_addr_q   <= '0;
      fw_data_q   <= '0;
      req_error_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      fw_addr_q   <= fw_addr_d;
      fw_data_q   <= fw_data_d;
      req_error_q <= req_error_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_rd_en           = (state_q == ST_READ);
  assign firmware_data_valid = (state_q == ST_RESP);
  assign mem_addr            = mem_addr_q;
  assign firmware_addr       = fw_addr_q;
  assign firmware_data       = fw_data_q;
  assign req_error           = req_error_q;
  assign drop_cnt            = drop_q;
  assign busy                = (state_q != ST_IDLE) || (fifo_count != '0);
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_fw_image_responder.sv
module tb_fw_image_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ML     = 2;
  localparam int IMG    = 65536;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] firmware_addr_req;
  logic              firmware_req_valid;
  logic              flush;
  logic              req_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] firmware_addr;
  logic [DATA_W-1:0] firmware_data;
  logic              firmware_data_valid;
  logic              req_error;
  logic [15:0]       drop_cnt;
  logic              busy;
  logic [1:0]        state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fw_image_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .MEM_LATENCY(ML), .IMAGE_BYTES(IMG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .firmware_addr_req(firmware_addr_req), .firmware_req_valid(firmware_req_valid),
    .flush(flush), .req_ready(req_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .firmware_addr(firmware_addr), .firmware_data(firmware_data),
    .firmware_data_valid(firmware_data_valid), .req_error(req_error),
    .drop_cnt(drop_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- memory model: synchronous ROM, ML-cycle latency ----------------
  logic [31:0] rom [16384];
  logic        pv [ML];
  logic [31:0] pa [ML];

  always @(posedge clk) begin
    pv[0] <= mem_rd_en;
    pa[0] <= mem_addr;
    for (int i = 1; i < ML; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rdata = pv[ML-1] ? rom[pa[ML-1][15:2]] : 32'hDEAD_BEEF;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc++;

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction-level view: a queue of requests (head stays until retired)
  // and a single server. When the server is free at cycle c with a queued
  // head, an illegal head errors at c+1; a legal head gets its read strobe
  // at c+1, its response at c+2+ML and frees the server at c+3+ML.
  logic [31:0] mq[$];
  int          cyc, free_at, rd_at, resp_at, err_at, e_drop;
  logic [31:0] resp_addr, err_addr, e_fw_addr, e_fw_data;
  logic        e_rd_en, e_valid, e_err, e_ready, e_busy;
  int          m_n0;
  logic        m_pop;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(IMG - 4));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cyc = 0; free_at = 0; rd_at = -1; resp_at = -1; err_at = -1; e_drop = 0;
      resp_addr = 0; err_addr = 0; e_fw_addr = 0; e_fw_data = 0;
      e_rd_en = 0; e_valid = 0; e_err = 0; e_ready = 1; e_busy = 0;
    end else begin
      m_n0  = mq.size();
      m_pop = 1'b0;
      if (flush) begin
        mq.delete();
        rd_at = -1; resp_at = -1; err_at = -1;
        free_at = cyc + 1;
      end else begin
        if (resp_at == cyc) m_pop = 1'b1;
        if (cyc >= free_at && m_n0 > 0) begin
          if (legal(mq[0])) begin
            resp_addr = mq[0];
            rd_at     = cyc + 1;
            resp_at   = cyc + 2 + ML;
            free_at   = cyc + 3 + ML;
          end else begin
            err_addr = mq[0];
            err_at   = cyc + 1;
            m_pop    = 1'b1;
          end
        end
        if (firmware_req_valid) begin
          if (m_n0 < DEPTH) mq.push_back(firmware_addr_req);
          else if (e_drop < 65535) e_drop++;
        end
        if (m_pop) void'(mq.pop_front());
      end
      cyc++;
      e_rd_en = (rd_at == cyc);
      e_valid = (resp_at == cyc);
      e_err   = (err_at == cyc);
      if (e_err) e_fw_addr = err_addr;
      if (e_valid) begin
        e_fw_addr = resp_addr;
        e_fw_data = rom[resp_addr[15:2]];
      end
      e_ready = (mq.size() < DEPTH);
      e_busy  = (cyc < free_at) || (mq.size() > 0);
    end
  end

  // One compare process, on the falling edge of every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("cmp_rd_en",  32'(mem_rd_en),           32'(e_rd_en));
      chk("cmp_valid",  32'(firmware_data_valid), 32'(e_valid));
      chk("cmp_error",  32'(req_error),           32'(e_err));
      chk("cmp_ready",  32'(req_ready),           32'(e_ready));
      chk("cmp_busy",   32'(busy),                32'(e_busy));
      chk("cmp_drop",   32'(drop_cnt),            32'(e_drop));
      chk("cmp_fwaddr", firmware_addr,            e_fw_addr);
      chk("cmp_fwdata", firmware_data,            e_fw_data);
      if (e_rd_en) chk("cmp_memaddr", mem_addr, resp_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] a);
    firmware_req_valid = 1'b1;
    firmware_addr_req  = a;
    tick();
    firmware_req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    bit ok;
    ok = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (firmware_data_valid === 1'b1) begin
        at = tb_cyc;
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no firmware_data_valid, expected one within 40 cycles (t=%0t)", $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, at, quiet;
    reset_n            = 1'b0;
    firmware_req_valid = 1'b0;
    firmware_addr_req  = '0;
    flush              = 1'b0;
    for (int i = 0; i < ML; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    for (int i = 0; i < 16384; i++) rom[i] = {16'hA5A5, 16'(i)};
    rom[0]     = 32'h0000_0100;
    for (int k = 1; k <= 4; k++) rom[k] = 32'(k);
    rom[16383] = 32'hCAFE_F00D;

    // reset state
    #12;
    chk("rst_rd_en",  32'(mem_rd_en), 0);
    chk("rst_valid",  32'(firmware_data_valid), 0);
    chk("rst_error",  32'(req_error), 0);
    chk("rst_fwaddr", firmware_addr, 0);
    chk("rst_fwdata", firmware_data, 0);
    chk("rst_drop",   32'(drop_cnt), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_ready",  32'(req_ready), 1);
    chk("rst_state",  32'(state_dbg), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    idle(2);

    // 1: single legal read, latency pinned
    n = tb_cyc;
    send(32'h0);
    tick();
    chk("t1_rd_en_n2",  32'(mem_rd_en), 1);
    chk("t1_memaddr",   mem_addr, 0);
    idle(2);
    chk("t1_no_valid_n4", 32'(firmware_data_valid), 0);
    tick();
    chk("t1_valid_n5",  32'(firmware_data_valid), 1);
    chk("t1_cycle",     32'(tb_cyc - n), 5);
    chk("t1_fwaddr",    firmware_addr, 0);
    chk("t1_fwdata",    firmware_data, 32'h0000_0100);
    tick();
    chk("t1_busy_n6",   32'(busy), 0);
    idle(2);

    // 2: five back-to-back strobes, fifth dropped, responses 5 cycles apart
    n = tb_cyc;
    for (int k = 1; k <= 5; k++) begin
      firmware_req_valid = 1'b1;
      firmware_addr_req  = 32'(4 * k);
      if (k == 5) chk("t2_ready_low", 32'(req_ready), 0);
      tick();
    end
    firmware_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(at);
      chk("t2_resp_cycle", 32'(at - n), 32'(5 * k));
      chk("t2_resp_addr",  firmware_addr, 32'(4 * k));
      chk("t2_resp_data",  firmware_data, 32'(k));
      tick();
    end
    chk("t2_drop", 32'(drop_cnt), 1);
    idle(3);

    // 3: misaligned address
    send(32'h6);
    tick();
    chk("t3_error",  32'(req_error), 1);
    chk("t3_fwaddr", firmware_addr, 32'h6);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      quiet += int'(mem_rd_en) + int'(firmware_data_valid);
      tick();
    end
    chk("t3_quiet", 32'(quiet), 0);
    chk("t3_drop",  32'(drop_cnt), 1);

    // 4: range boundaries
    n = tb_cyc;
    firmware_req_valid = 1'b1;
    firmware_addr_req  = 32'h0001_0000;
    tick();
    firmware_addr_req  = 32'h0000_FFFC;
    tick();
    firmware_req_valid = 1'b0;
    chk("t4_err_10000",  32'(req_error), 1);
    chk("t4_err_addr",   firmware_addr, 32'h0001_0000);
    wait_valid(at);
    chk("t4_last_cycle", 32'(at - n), 6);
    chk("t4_last_addr",  firmware_addr, 32'h0000_FFFC);
    chk("t4_last_data",  firmware_data, 32'hCAFE_F00D);
    idle(2);
    send(32'hFFFF_FFFC);
    tick();
    chk("t4_err_top",    32'(req_error), 1);
    chk("t4_err_topaddr", firmware_addr, 32'hFFFF_FFFC);
    idle(3);

    // 5: flush while the first of three is in WAIT; strobe in flush cycle discarded
    send(32'h0);
    send(32'h4);
    send(32'h8);
    flush              = 1'b1;
    firmware_req_valid = 1'b1;
    firmware_addr_req  = 32'hC;
    tick();
    flush              = 1'b0;
    firmware_req_valid = 1'b0;
    chk("t5_busy",  32'(busy), 0);
    chk("t5_ready", 32'(req_ready), 1);
    chk("t5_rd_en", 32'(mem_rd_en), 0);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      quiet += int'(mem_rd_en) + int'(firmware_data_valid) + int'(req_error);
      tick();
    end
    chk("t5_quiet", 32'(quiet), 0);
    chk("t5_drop",  32'(drop_cnt), 1);
    send(32'h8);
    wait_valid(at);
    chk("t5_after_addr", firmware_addr, 32'h8);
    chk("t5_after_data", firmware_data, 32'h2);
    idle(3);

    // 6: async reset mid-WAIT with drop_cnt=3, stale read data ignored
    for (int k = 0; k < 6; k++) begin
      firmware_req_valid = 1'b1;
      firmware_addr_req  = 32'h10 + 32'(4 * k);
      tick();
    end
    firmware_req_valid = 1'b0;
    chk("t6_drop3", 32'(drop_cnt), 3);
    tick();
    chk("t6_second_rd", 32'(mem_rd_en), 1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_rd_en",  32'(mem_rd_en), 0);
    chk("t6_rst_valid",  32'(firmware_data_valid), 0);
    chk("t6_rst_error",  32'(req_error), 0);
    chk("t6_rst_fwaddr", firmware_addr, 0);
    chk("t6_rst_fwdata", firmware_data, 0);
    chk("t6_rst_drop",   32'(drop_cnt), 0);
    chk("t6_rst_busy",   32'(busy), 0);
    chk("t6_rst_memaddr", mem_addr, 0);
    #4 reset_n = 1'b1;
    idle(3);
    n = tb_cyc;
    send(32'h0);
    wait_valid(at);
    chk("t6_new_cycle", 32'(at - n), 5);
    chk("t6_new_addr",  firmware_addr, 0);
    chk("t6_new_data",  firmware_data, 32'h0000_0100);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
